// File: rtl/ram_stream_reader.sv
// ram_stream_reader: streams length words from a 2-cycle-latency RAM read port, starting at base_addr
// ports: clk, rst_n (sync, active low); start/base_addr/length launch a transfer, busy/done report it;
//        addr_rd/data_rd drive the RAM read port; m_data/m_valid/m_ready/m_last form the output stream
module ram_stream_reader #(
   parameter int RAM_WIDTH  = 8,
   parameter int RAM_DEPTH  = 1024,
   parameter int FIFO_DEPTH = 4,
   localparam int AW = $clog2(RAM_DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [AW-1:0]        base_addr,
   input  logic [AW:0]          length,
   output logic                 busy,
   output logic                 done,
   output logic [AW-1:0]        addr_rd,
   input  logic [RAM_WIDTH-1:0] data_rd,
   output logic [RAM_WIDTH-1:0] m_data,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic                 m_last
);
   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int OW = $clog2(FIFO_DEPTH + 1);
   localparam int CW = OW + 3;
   state_t state, state_nxt;
   logic [RAM_WIDTH-1:0] fifo [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [OW-1:0] occ;
   logic [AW:0] len_q, issued, beat_cnt;
   // tag[0]: addr_rd holds a freshly issued address; tag[2]: that word's data is on data_rd now
   logic [2:0] tag;
   logic launch, issue, credit_ok, done_nxt, pop, push;
   logic [CW-1:0] demand;
   logic [AW-1:0] addr_inc;
   assign push = tag[2];
   assign pop = m_valid & m_ready;
   assign m_valid = occ != '0;
   assign m_data = m_valid ? fifo[rd_ptr] : '0;
   assign m_last = m_valid && beat_cnt == len_q - 1'b1;
   assign busy = state != IDLE;
   // every word already issued owns a FIFO slot, so a new issue needs one free after this cycle's pop
   assign demand = CW'(occ) + CW'(tag[0]) + CW'(tag[1]) + CW'(tag[2]) + CW'(1) - CW'(pop);
   assign credit_ok = demand <= CW'(FIFO_DEPTH);
   assign addr_inc = (addr_rd == AW'(RAM_DEPTH - 1)) ? '0 : addr_rd + 1'b1;
   always_comb begin
      state_nxt = state;
      launch = 1'b0;
      issue = 1'b0;
      done_nxt = 1'b0;
      case (state)
         IDLE: begin
            launch = start && length != '0;
            done_nxt = start && length == '0;
            state_nxt = launch ? READ : IDLE;
         end
         READ: begin
            issue = issued != len_q && credit_ok;
            state_nxt = (issued == len_q) ? DRAIN : READ;
         end
         DRAIN: begin
            done_nxt = pop && m_last;
            state_nxt = done_nxt ? IDLE : DRAIN;
         end
         default: state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         done <= 1'b0;
         tag <= '0;
         addr_rd <= '0;
         len_q <= '0;
         issued <= '0;
         beat_cnt <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ <= '0;
      end else begin
         state <= state_nxt;
         done <= done_nxt;
         tag <= {tag[1:0], launch | issue};
         if (launch) begin
            addr_rd <= base_addr;
            len_q <= length;
            issued <= {{AW{1'b0}}, 1'b1};
         end else if (issue) begin
            addr_rd <= addr_inc;
            issued <= issued + 1'b1;
         end
         if (launch) beat_cnt <= '0;
         else if (pop) beat_cnt <= beat_cnt + 1'b1;
         if (push) wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         if (pop) rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         occ <= occ + OW'(push) - OW'(pop);
      end
   end
   always_ff @(posedge clk) begin
      if (push) fifo[wr_ptr] <= data_rd;
   end
endmodule

// File: tb/tb_ram_stream_reader.sv
// tb_ram_stream_reader: randomized and directed checks of ram_stream_reader against a word-list model
module tb_ram_stream_reader;
   localparam int FD = 4;
   localparam int LIM = 2000;
   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, m_ready = 1'b0;
   logic [9:0] base_addr = '0;
   logic [10:0] length = '0;
   logic busy, done, m_valid, m_last;
   logic [9:0] addr_rd;
   logic [7:0] data_rd, m_data, ram_q;
   logic [7:0] ram [1024];
   int checks = 0, passed = 0;
   logic v_log [2048], l_log [2048], b_log [2048], r_log [2048];
   logic [7:0] d_log [2048];
   logic [9:0] a_log [2048];
   int iss_log [2048];
   logic [7:0] got_d [$];
   logic got_l [$];
   int beat_c [$];
   int done_c, max_out, stab_err;
   logic timed_out;

   ram_stream_reader #(.RAM_WIDTH(8), .RAM_DEPTH(1024), .FIFO_DEPTH(FD)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
      .busy(busy), .done(done), .addr_rd(addr_rd), .data_rd(data_rd),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
   );

   always #5 clk = ~clk;

   // RAM read port: two register stages from address to data
   always @(posedge clk) begin
      ram_q <= ram[addr_rd];
      data_rd <= ram_q;
   end

   function automatic logic [7:0] exp_word(input int b, input int k);
      return ram[(b + k) % 1024];
   endfunction

   task automatic fill_ramp();
      for (int i = 0; i < 1024; i++) ram[i] = 8'(i);
   endtask

   task automatic fill_rand();
      for (int i = 0; i < 1024; i++) ram[i] = 8'($urandom);
   endtask

   // mode 0: always ready, 1: stalled in cycles 4..12, 2: random; mid_c: cycle of a stray start pulse
   task automatic run_xfer(input int b, input int n, input int mode, input int mid_c);
      int acc, iss;
      logic [9:0] pa;
      got_d.delete();
      got_l.delete();
      beat_c.delete();
      done_c = -1;
      max_out = 0;
      stab_err = 0;
      timed_out = 1'b0;
      acc = 0;
      iss = 0;
      pa = '0;
      @(negedge clk);
      base_addr = 10'(b);
      length = 11'(n);
      start = 1'b1;
      m_ready = 1'b1;
      for (int c = 1; c < LIM; c++) begin
         @(negedge clk);
         start = (c == mid_c);
         if (c == mid_c) begin
            base_addr = 10'h300;
            length = 11'd3;
         end
         m_ready = (mode == 0) ? 1'b1 : (mode == 1) ? !(c >= 4 && c <= 12) : ($urandom % 4 != 0);
         v_log[c] = m_valid;
         d_log[c] = m_data;
         l_log[c] = m_last;
         a_log[c] = addr_rd;
         b_log[c] = busy;
         if (busy && (iss == 0 || addr_rd != pa)) iss++;
         pa = addr_rd;
         iss_log[c] = iss;
         if (iss - acc > max_out) max_out = iss - acc;
         if (c > 1 && v_log[c-1] && !r_log[c-1] &&
             (!m_valid || m_data !== d_log[c-1] || m_last !== l_log[c-1])) stab_err++;
         r_log[c] = m_ready;
         if (m_valid && m_ready) begin
            got_d.push_back(m_data);
            got_l.push_back(m_last);
            beat_c.push_back(c);
            acc++;
         end
         if (done) begin
            done_c = c;
            break;
         end
      end
      start = 1'b0;
      if (done_c < 0) timed_out = 1'b1;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
      checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passed++;
      checks++; if (m_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", m_valid); else passed++;
      checks++; if (m_last !== 1'b0) $display("FAIL reset_last: got %b want 0", m_last); else passed++;
      checks++; if (addr_rd !== 10'd0) $display("FAIL reset_addr: got %0h want 0", addr_rd); else passed++;
      checks++; if (m_data !== 8'd0) $display("FAIL reset_data: got %0h want 0", m_data); else passed++;
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      int bc;
      fill_ramp();
      run_xfer(16, 4, 0, -1);
      checks++; if (timed_out !== 1'b0) $display("FAIL basic_timeout: got %b want 0", timed_out); else passed++;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (a_log[k+1] !== 10'(16 + k)) $display("FAIL basic_addr%0d: got %0h want %0h", k, a_log[k+1], 16 + k);
         else passed++;
      end
      checks++; if (got_d.size() != 4) $display("FAIL basic_count: got %0d want 4", got_d.size()); else passed++;
      for (int k = 0; k < got_d.size(); k++) begin
         checks++;
         if (got_d[k] !== exp_word(16, k)) $display("FAIL basic_data%0d: got %0h want %0h", k, got_d[k], exp_word(16, k));
         else passed++;
         checks++;
         if (beat_c[k] != 4 + k) $display("FAIL basic_beatcyc%0d: got %0d want %0d", k, beat_c[k], 4 + k);
         else passed++;
         checks++;
         if (got_l[k] !== (k == 3)) $display("FAIL basic_last%0d: got %b want %b", k, got_l[k], k == 3);
         else passed++;
      end
      checks++; if (done_c != 8) $display("FAIL basic_donecyc: got %0d want 8", done_c); else passed++;
      bc = 0;
      for (int c = 1; c <= done_c && c > 0; c++) bc += int'(b_log[c]);
      checks++; if (bc != 7 || b_log[1] !== 1'b1) $display("FAIL basic_busy: got %0d cycles want 7 from cycle 1", bc); else passed++;
   endtask

   task automatic test_wrap();
      fill_ramp();
      run_xfer(1022, 4, 0, -1);
      checks++; if (timed_out !== 1'b0) $display("FAIL wrap_timeout: got %b want 0", timed_out); else passed++;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (a_log[k+1] !== 10'((1022 + k) % 1024)) $display("FAIL wrap_addr%0d: got %0d want %0d", k, a_log[k+1], (1022 + k) % 1024);
         else passed++;
      end
      checks++; if (got_d.size() != 4) $display("FAIL wrap_count: got %0d want 4", got_d.size()); else passed++;
      for (int k = 0; k < got_d.size(); k++) begin
         checks++;
         if (got_d[k] !== exp_word(1022, k) || got_l[k] !== (k == 3))
            $display("FAIL wrap_beat%0d: got %0h/%b want %0h/%b", k, got_d[k], got_l[k], exp_word(1022, k), k == 3);
         else passed++;
      end
   endtask

   task automatic test_backpressure();
      int bad;
      fill_ramp();
      run_xfer(16, 8, 1, -1);
      checks++; if (timed_out !== 1'b0) $display("FAIL bp_timeout: got %b want 0", timed_out); else passed++;
      checks++; if (max_out > FD) $display("FAIL bp_credit: got %0d outstanding want <= %0d", max_out, FD); else passed++;
      checks++; if (iss_log[12] != 4) $display("FAIL bp_freeze: got %0d issued by cycle 12 want 4", iss_log[12]); else passed++;
      bad = 0;
      for (int c = 4; c <= 12; c++) if (!v_log[c] || d_log[c] !== 8'h10) bad++;
      checks++; if (bad != 0) $display("FAIL bp_hold: got %0d bad stall cycles want 0", bad); else passed++;
      checks++; if (stab_err != 0) $display("FAIL bp_stable: got %0d changes want 0", stab_err); else passed++;
      checks++; if (got_d.size() != 8) $display("FAIL bp_count: got %0d want 8", got_d.size()); else passed++;
      bad = 0;
      for (int k = 0; k < got_d.size(); k++) if (got_d[k] !== exp_word(16, k) || got_l[k] !== (k == 7)) bad++;
      checks++; if (bad != 0) $display("FAIL bp_order: got %0d bad beats want 0", bad); else passed++;
   endtask

   task automatic test_zero_len();
      run_xfer(85, 0, 0, -1);
      checks++; if (done_c != 1) $display("FAIL zero_donecyc: got %0d want 1", done_c); else passed++;
      checks++; if (b_log[1] !== 1'b0) $display("FAIL zero_busy: got %b want 0", b_log[1]); else passed++;
      checks++; if (got_d.size() != 0) $display("FAIL zero_beats: got %0d want 0", got_d.size()); else passed++;
      repeat (4) begin
         @(negedge clk);
         checks++; if (m_valid !== 1'b0 || busy !== 1'b0) $display("FAIL zero_idle: got valid %b busy %b want 0 0", m_valid, busy); else passed++;
      end
   endtask

   task automatic test_mid_start();
      int bad;
      fill_rand();
      run_xfer(32, 6, 0, 3);
      checks++; if (done_c != 10) $display("FAIL mid_donecyc: got %0d want 10", done_c); else passed++;
      checks++; if (got_d.size() != 6) $display("FAIL mid_count: got %0d want 6", got_d.size()); else passed++;
      bad = 0;
      for (int k = 0; k < got_d.size(); k++) if (got_d[k] !== exp_word(32, k)) bad++;
      checks++; if (bad != 0) $display("FAIL mid_data: got %0d bad beats want 0", bad); else passed++;
      repeat (3) @(negedge clk);
      checks++; if (busy !== 1'b0 || m_valid !== 1'b0) $display("FAIL mid_relaunch: got busy %b valid %b want 0 0", busy, m_valid); else passed++;
   endtask

   task automatic test_reset_mid();
      int stale;
      fill_ramp();
      @(negedge clk);
      base_addr = 10'h040;
      length = 11'd8;
      start = 1'b1;
      m_ready = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if ({busy, done, m_valid, m_last} !== 4'b0 || addr_rd !== 10'd0 || m_data !== 8'd0)
         $display("FAIL rstmid_zero: got b%b d%b v%b l%b a%0h m%0h want all 0", busy, done, m_valid, m_last, addr_rd, m_data);
      else passed++;
      rst_n = 1'b1;
      stale = 0;
      repeat (6) begin
         @(negedge clk);
         if (m_valid) stale++;
      end
      checks++; if (stale != 0) $display("FAIL rstmid_stale: got %0d valid cycles want 0", stale); else passed++;
      run_xfer(256, 2, 0, -1);
      checks++; if (got_d.size() != 2) $display("FAIL rstmid_count: got %0d want 2", got_d.size()); else passed++;
      for (int k = 0; k < got_d.size(); k++) begin
         checks++;
         if (got_d[k] !== 8'(k) || got_l[k] !== (k == 1)) $display("FAIL rstmid_beat%0d: got %0h/%b want %0h/%b", k, got_d[k], got_l[k], k, k == 1);
         else passed++;
      end
   endtask

   task automatic test_random();
      int b, n, bad;
      for (int it = 0; it < 6; it++) begin
         fill_rand();
         b = $urandom_range(0, 1023);
         n = $urandom_range(1, 40);
         run_xfer(b, n, 2, -1);
         checks++; if (timed_out !== 1'b0) $display("FAIL rand%0d_timeout: got %b want 0", it, timed_out); else passed++;
         checks++; if (got_d.size() != n) $display("FAIL rand%0d_count: got %0d want %0d", it, got_d.size(), n); else passed++;
         bad = 0;
         for (int k = 0; k < got_d.size(); k++) if (got_d[k] !== exp_word(b, k) || got_l[k] !== (k == n - 1)) bad++;
         checks++; if (bad != 0) $display("FAIL rand%0d_data: got %0d bad beats want 0", it, bad); else passed++;
         checks++; if (max_out > FD) $display("FAIL rand%0d_credit: got %0d want <= %0d", it, max_out, FD); else passed++;
         checks++; if (stab_err != 0) $display("FAIL rand%0d_stable: got %0d want 0", it, stab_err); else passed++;
      end
   endtask

   task automatic test_full_rate();
      int bad;
      fill_ramp();
      run_xfer(0, 1024, 0, -1);
      checks++; if (got_d.size() != 1024) $display("FAIL full_count: got %0d want 1024", got_d.size()); else passed++;
      if (got_d.size() == 1024) begin
         checks++; if (beat_c[0] != 4) $display("FAIL full_first: got %0d want 4", beat_c[0]); else passed++;
         checks++; if (beat_c[1023] != 1027) $display("FAIL full_lastcyc: got %0d want 1027", beat_c[1023]); else passed++;
      end
      bad = 0;
      for (int k = 0; k < got_d.size(); k++) if (got_d[k] !== exp_word(0, k) || got_l[k] !== (k == 1023)) bad++;
      checks++; if (bad != 0) $display("FAIL full_data: got %0d bad beats want 0", bad); else passed++;
      checks++; if (done_c != 1028) $display("FAIL full_donecyc: got %0d want 1028", done_c); else passed++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_backpressure();
      test_zero_len();
      test_mid_start();
      test_reset_mid();
      test_random();
      test_full_rate();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
